// File: rtl/hgw_apb_pkg.sv
// -----------------------------------------------------------------------------
// hgw_apb_pkg
// Shared definitions for the APB master / arbiter slice.
//   DW           : APB data width (fixed at 32)
//   apb_state_t  : APB master phase encoding (IDLE=0, SETUP=1, ACCESS=2)
// -----------------------------------------------------------------------------
package hgw_apb_pkg;

  localparam int DW = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_t;

endpackage : hgw_apb_pkg

// File: rtl/hgw_rr_arb.sv
// -----------------------------------------------------------------------------
// hgw_rr_arb
// Round-robin arbiter. The search starts one past the last granted index and
// wraps modulo NREQ; the pointer moves to the winner whenever a grant is taken.
// After reset the pointer sits at NREQ-1 so requester 0 wins first.
// Ports:
//   pclk, presetn : clock / async active-low reset
//   req           : eligible requests, one bit per requester
//   en            : grant enable (arbitration only happens while high)
//   gnt_idx       : index of the winning requester
//   gnt_vld       : a winner exists and en is high
// -----------------------------------------------------------------------------
module hgw_rr_arb #(
  parameter  int NREQ = 2,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            pclk,
  input  logic            presetn,
  input  logic [NREQ-1:0] req,
  input  logic            en,
  output logic [IW-1:0]   gnt_idx,
  output logic            gnt_vld
);

  logic [IW-1:0] last_gnt;

  // NOTE: every variable written in always_comb gets a default before any
  // conditional assignment, otherwise synthesis infers a latch to hold it.
  always_comb begin
    int cand;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = int'(last_gnt) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      if (en && !gnt_vld && req[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = IW'(cand);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its inputs from the same pre-edge values regardless of statement order.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      last_gnt <= IW'(NREQ - 1);
    end else if (gnt_vld) begin
      last_gnt <= gnt_idx;
    end
  end

endmodule : hgw_rr_arb

// File: rtl/hgw_apb_mst_arb.sv
// -----------------------------------------------------------------------------
// hgw_apb_mst_arb
// Arbitrates NREQ simple request/ack clients onto one APB master port.
// A winner's command is registered in IDLE, driven through SETUP and ACCESS,
// and completion is reported with a one-cycle o_ack pulse to that requester.
// An optional ACCESS-phase timeout (TO_CYC>0) completes the transfer with an
// error when the completer never raises pready.
// Ports:
//   pclk, presetn        : clock / async active-low reset
//   i_req, i_wr          : per-requester request and direction (1 = write)
//   i_addr, i_wdata      : packed per-requester address / write data
//   o_ack                : one-cycle completion pulse per requester
//   o_rdata, o_err       : completion data / error, valid with o_ack, held after
//   paddr..pwdata        : APB master request
//   pready, pslverr      : APB completer response (sampled only in ACCESS)
//   prdata               : APB completer read data
// -----------------------------------------------------------------------------
module hgw_apb_mst_arb
  import hgw_apb_pkg::*;
#(
  parameter int BW     = 16,
  parameter int NREQ   = 2,
  parameter int TO_CYC = 255
) (
  input  logic               pclk,
  input  logic               presetn,
  input  logic [NREQ-1:0]    i_req,
  input  logic [NREQ-1:0]    i_wr,
  input  logic [NREQ*BW-1:0] i_addr,
  input  logic [NREQ*DW-1:0] i_wdata,
  output logic [NREQ-1:0]    o_ack,
  output logic [DW-1:0]      o_rdata,
  output logic               o_err,
  output logic [BW-1:0]      paddr,
  output logic               psel,
  output logic               penable,
  output logic               pwrite,
  output logic [DW-1:0]      pwdata,
  input  logic               pready,
  input  logic               pslverr,
  input  logic [DW-1:0]      prdata
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (TO_CYC > 0) ? $clog2(TO_CYC + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = (TO_CYC > 0) ? CW'(TO_CYC - 1) : '0;

  apb_state_t    state, state_nxt;
  logic [CW-1:0] to_cnt;
  logic [IW-1:0] win_idx;
  logic [IW-1:0] gnt_idx;
  logic          gnt_vld;
  logic          xfer_done;
  logic          xfer_tmo;

  // A requester is not eligible in the cycle its ack is visible, so a client
  // that has not yet dropped i_req cannot be granted a duplicate transfer.
  hgw_rr_arb #(.NREQ(NREQ)) u_arb (
    .pclk    (pclk),
    .presetn (presetn),
    .req     (i_req & ~o_ack),
    .en      (state == ST_IDLE),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  assign psel      = (state != ST_IDLE);
  assign penable   = (state == ST_ACCESS);
  assign xfer_done = (state == ST_ACCESS) && pready;
  // to_cnt counts completed wait cycles, so reaching TO_LAST with pready still
  // low means this is the TO_CYC-th ACCESS cycle.
  assign xfer_tmo  = (TO_CYC > 0) && (state == ST_ACCESS) && !pready && (to_cnt == TO_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (gnt_vld) state_nxt = ST_SETUP;
      ST_SETUP:  state_nxt = ST_ACCESS;
      ST_ACCESS: if (xfer_done || xfer_tmo) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      win_idx <= '0;
      pwrite  <= 1'b0;
      paddr   <= '0;
      pwdata  <= '0;
      to_cnt  <= '0;
      o_ack   <= '0;
      o_rdata <= '0;
      o_err   <= 1'b0;
    end else begin
      o_ack <= '0;
      if (state == ST_IDLE && gnt_vld) begin
        win_idx <= gnt_idx;
        pwrite  <= i_wr[gnt_idx];
        paddr   <= i_addr[int'(gnt_idx)*BW +: BW];
        pwdata  <= i_wdata[int'(gnt_idx)*DW +: DW];
        to_cnt  <= '0;
      end
      if (state == ST_ACCESS && !pready) begin
        to_cnt <= to_cnt + CW'(1);
      end
      if (xfer_done || xfer_tmo) begin
        o_ack[win_idx] <= 1'b1;
        o_rdata        <= (xfer_done && !pwrite) ? prdata : '0;
        o_err          <= xfer_tmo ? 1'b1 : pslverr;
      end
    end
  end

endmodule : hgw_apb_mst_arb

// File: tb/tb_hgw_apb_mst_arb.sv
// -----------------------------------------------------------------------------
// tb_hgw_apb_mst_arb
// Self-checking bench for hgw_apb_mst_arb (BW=16, NREQ=3, TO_CYC=4).
// A behavioural APB completer answers with configurable or random wait states
// and error responses and logs every completed transfer; scenario tasks and a
// randomized round-robin run compare the DUT against expectations derived from
// the arbitration and timing rules.
// -----------------------------------------------------------------------------
module tb_hgw_apb_mst_arb;

  localparam int BW     = 16;
  localparam int NREQ   = 3;
  localparam int TO_CYC = 4;

  logic               pclk    = 1'b0;
  logic               presetn = 1'b0;
  logic [NREQ-1:0]    i_req   = '0;
  logic [NREQ-1:0]    i_wr    = '0;
  logic [NREQ*BW-1:0] i_addr  = '0;
  logic [NREQ*32-1:0] i_wdata = '0;
  logic [NREQ-1:0]    o_ack;
  logic [31:0]        o_rdata;
  logic               o_err;
  logic [BW-1:0]      paddr;
  logic               psel, penable, pwrite;
  logic [31:0]        pwdata;
  logic               pready  = 1'b0;
  logic               pslverr = 1'b0;
  logic [31:0]        prdata  = '0;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  hgw_apb_mst_arb #(.BW(BW), .NREQ(NREQ), .TO_CYC(TO_CYC)) dut (
    .pclk(pclk), .presetn(presetn), .i_req(i_req), .i_wr(i_wr), .i_addr(i_addr),
    .i_wdata(i_wdata), .o_ack(o_ack), .o_rdata(o_rdata), .o_err(o_err),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .pready(pready), .pslverr(pslverr), .prdata(prdata)
  );

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  // ---------------- behavioural APB completer ----------------
  int          wait_cfg    = 0;
  bit          err_cfg     = 1'b0;
  bit          rand_mode   = 1'b0;
  bit          use_fixed   = 1'b0;
  logic [31:0] fixed_rdata = '0;
  int          wcnt        = 0;
  int          cur_wait    = 0;
  bit          cur_err     = 1'b0;

  typedef struct {
    logic [BW-1:0] addr;
    logic          wr;
    logic [31:0]   wdata;
    int            waits;
    bit            err;
    int            at;
  } xfer_t;
  xfer_t slv_log[$];

  function automatic logic [31:0] rd_fn(input logic [BW-1:0] a);
    return {a, ~a};
  endfunction

  always @(negedge pclk) begin
    if (psel && penable) begin
      if (wcnt == 0) begin
        if (rand_mode) begin
          cur_wait = $urandom_range(0, 2);
          cur_err  = 1'($urandom_range(0, 1));
        end else begin
          cur_wait = wait_cfg;
          cur_err  = err_cfg;
        end
      end
      prdata = use_fixed ? fixed_rdata : rd_fn(paddr);
      if (wcnt >= cur_wait) begin
        pready  = 1'b1;
        pslverr = cur_err;
        slv_log.push_back('{paddr, pwrite, pwdata, cur_wait, cur_err, cyc});
        wcnt    = 0;
      end else begin
        pready  = 1'b0;
        pslverr = 1'($urandom_range(0, 1));
        wcnt++;
      end
    end else begin
      // Junk outside ACCESS: the master must not react to it.
      pready  = 1'($urandom_range(0, 1));
      pslverr = 1'($urandom_range(0, 1));
      prdata  = $urandom;
      wcnt    = 0;
    end
  end

  // ---------------- helpers ----------------
  task automatic set_cmd(input int k, input logic wr, input logic [BW-1:0] a, input logic [31:0] d);
    i_wr[k]             = wr;
    i_addr[k*BW +: BW]  = a;
    i_wdata[k*32 +: 32] = d;
  endtask

  // Start of a fresh cycle; returns its cycle number.
  task automatic to_t0(output int t0);
    @(posedge pclk);
    #1;
    t0 = cyc;
  endtask

  // Waits up to limit cycles for an ack; idx=-1 on timeout, -2 if not one-hot.
  task automatic wait_ack(input int limit, output int idx, output int at);
    bit got;
    got = 1'b0;
    idx = -1;
    at  = -1;
    for (int n = 0; n <= limit && !got; n++) begin
      @(negedge pclk);
      if (|o_ack) begin
        got = 1'b1;
        at  = cyc;
        if ($countones(o_ack) != 1) idx = -2;
        else for (int k = 0; k < NREQ; k++) if (o_ack[k]) idx = k;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    presetn = 1'b0;
    i_req   = '0;
    repeat (2) @(negedge pclk);
    checks++; if ({psel, penable, pwrite, o_err} !== 4'b0) begin failures++;
      $display("FAIL reset_ctrl got psel/pen/pwr/err=%b exp=0000", {psel, penable, pwrite, o_err}); end
    checks++; if (paddr !== '0) begin failures++; $display("FAIL reset_paddr got=%h exp=0", paddr); end
    checks++; if (pwdata !== '0) begin failures++; $display("FAIL reset_pwdata got=%h exp=0", pwdata); end
    checks++; if (o_ack !== '0) begin failures++; $display("FAIL reset_ack got=%b exp=0", o_ack); end
    checks++; if (o_rdata !== '0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", o_rdata); end
    @(posedge pclk);
    #1 presetn = 1'b1;
  endtask

  task automatic test_single_write();
    int t0;
    wait_cfg = 0; err_cfg = 0; use_fixed = 0;
    to_t0(t0);
    set_cmd(0, 1'b1, 16'h0010, 32'hA5A5_0001);
    i_req = 3'b001;
    @(negedge pclk);  // T0
    checks++; if (psel !== 1'b0) begin failures++; $display("FAIL wr_t0_psel got=%b exp=0", psel); end
    @(negedge pclk);  // T1
    checks++; if ({psel, penable} !== 2'b10) begin failures++; $display("FAIL wr_t1_phase got=%b exp=10", {psel, penable}); end
    checks++; if ({paddr, pwrite, pwdata} !== {16'h0010, 1'b1, 32'hA5A5_0001}) begin failures++;
      $display("FAIL wr_t1_cmd got=%h/%b/%h exp=0010/1/a5a50001", paddr, pwrite, pwdata); end
    @(negedge pclk);  // T2
    checks++; if ({psel, penable, paddr} !== {2'b11, 16'h0010}) begin failures++;
      $display("FAIL wr_t2_access got=%b/%h exp=11/0010", {psel, penable}, paddr); end
    @(negedge pclk);  // T3
    checks++; if (o_ack !== 3'b001) begin failures++; $display("FAIL wr_t3_ack got=%b exp=001", o_ack); end
    checks++; if ({o_err, o_rdata} !== 33'b0) begin failures++; $display("FAIL wr_t3_resp got=%b/%h exp=0/0", o_err, o_rdata); end
    i_req = '0;
  endtask

  task automatic test_read_wait();
    int t0, idx, at;
    wait_cfg = 2; err_cfg = 0; use_fixed = 1; fixed_rdata = 32'h1234_5678;
    to_t0(t0);
    set_cmd(1, 1'b0, 16'h0020, 32'hFFFF_FFFF);
    i_req = 3'b010;
    wait_ack(12, idx, at);
    i_req = '0;
    checks++; if (idx !== 1) begin failures++; $display("FAIL rd_ack_idx got=%0d exp=1", idx); end
    checks++; if (at - t0 !== 5) begin failures++; $display("FAIL rd_latency got=%0d exp=5", at - t0); end
    checks++; if ({o_err, o_rdata} !== {1'b0, 32'h1234_5678}) begin failures++;
      $display("FAIL rd_resp got=%b/%h exp=0/12345678", o_err, o_rdata); end
    repeat (2) @(negedge pclk);
    checks++; if ({o_ack, o_rdata} !== {3'b000, 32'h1234_5678}) begin failures++;
      $display("FAIL rd_hold got=%b/%h exp=000/12345678", o_ack, o_rdata); end
  endtask

  task automatic test_slverr();
    int t0, idx, at;
    wait_cfg = 1; err_cfg = 1; use_fixed = 1; fixed_rdata = 32'hCAFE_F00D;
    to_t0(t0);
    set_cmd(2, 1'b0, 16'h0030, 32'h0);
    i_req = 3'b100;
    wait_ack(12, idx, at);
    i_req = '0;
    checks++; if (idx !== 2 || at - t0 !== 4) begin failures++;
      $display("FAIL err_ack got idx=%0d lat=%0d exp idx=2 lat=4", idx, at - t0); end
    checks++; if ({o_err, o_rdata} !== {1'b1, 32'hCAFE_F00D}) begin failures++;
      $display("FAIL err_resp got=%b/%h exp=1/cafef00d", o_err, o_rdata); end
    // A clean write right after: error clears and write data reads back as 0.
    err_cfg = 0;
    to_t0(t0);
    set_cmd(0, 1'b1, 16'h0034, 32'h0BAD_0001);
    i_req = 3'b001;
    wait_ack(12, idx, at);
    i_req = '0;
    checks++; if (idx !== 0 || {o_err, o_rdata} !== 33'b0) begin failures++;
      $display("FAIL err_clear got idx=%0d err/rdata=%b/%h exp idx=0 0/0", idx, o_err, o_rdata); end
  endtask

  task automatic test_timeout();
    int t0, idx, at;
    wait_cfg = 1000; err_cfg = 0; use_fixed = 1; fixed_rdata = 32'hDEAD_BEEF;
    to_t0(t0);
    set_cmd(1, 1'b0, 16'h0040, 32'h0);
    i_req = 3'b010;
    wait_ack(20, idx, at);
    i_req = '0;
    checks++; if (idx !== 1 || at - t0 !== 6) begin failures++;
      $display("FAIL tmo_ack got idx=%0d lat=%0d exp idx=1 lat=6", idx, at - t0); end
    checks++; if ({o_err, o_rdata} !== {1'b1, 32'h0}) begin failures++;
      $display("FAIL tmo_resp got=%b/%h exp=1/0", o_err, o_rdata); end
    @(negedge pclk);
    checks++; if (psel !== 1'b0) begin failures++; $display("FAIL tmo_release got psel=%b exp=0", psel); end
    wait_cfg = 0;
  endtask

  task automatic test_back_to_back();
    int t0, idx, at;
    presetn = 1'b0;
    wait_cfg = 0; err_cfg = 0; use_fixed = 0;
    set_cmd(0, 1'b1, 16'h0100, 32'h1111_0000);
    set_cmd(1, 1'b0, 16'h0200, 32'h0);
    i_req = 3'b011;
    to_t0(t0);
    presetn = 1'b1;
    for (int n = 0; n < 4; n++) begin
      wait_ack(10, idx, at);
      checks++; if (idx !== n % 2 || at - t0 !== 3 * (n + 1)) begin failures++;
        $display("FAIL b2b_ack%0d got idx=%0d cyc=%0d exp idx=%0d cyc=%0d", n, idx, at - t0, n % 2, 3 * (n + 1)); end
      checks++; if (o_rdata !== ((n % 2 == 1) ? rd_fn(16'h0200) : 32'h0)) begin failures++;
        $display("FAIL b2b_rdata%0d got=%h", n, o_rdata); end
    end
    i_req = '0;
  endtask

  task automatic test_reset_mid();
    int t0, idx, at;
    bit acked;
    wait_cfg = 1000;
    to_t0(t0);
    set_cmd(0, 1'b0, 16'h0050, 32'h0);
    i_req = 3'b001;
    repeat (3) @(negedge pclk);  // T2: in ACCESS, stuck
    checks++; if ({psel, penable} !== 2'b11) begin failures++; $display("FAIL rstmid_pre got=%b exp=11", {psel, penable}); end
    #2 presetn = 1'b0;
    #1;
    checks++; if ({psel, penable} !== 2'b00) begin failures++; $display("FAIL rstmid_psel got=%b exp=00", {psel, penable}); end
    wait_cfg = 0;
    set_cmd(1, 1'b1, 16'h0060, 32'h6666_6666);
    i_req = 3'b011;
    acked = 1'b0;
    repeat (3) begin @(negedge pclk); if (|o_ack) acked = 1'b1; end
    to_t0(t0);
    presetn = 1'b1;
    if (|o_ack) acked = 1'b1;
    checks++; if (acked) begin failures++; $display("FAIL rstmid_noack got ack during reset exp none"); end
    wait_ack(10, idx, at);
    i_req = '0;
    checks++; if (idx !== 0 || at - t0 !== 3) begin failures++;
      $display("FAIL rstmid_first got idx=%0d lat=%0d exp idx=0 lat=3", idx, at - t0); end
  endtask

  task automatic test_random();
    int t0, idx, at, prev_at, ptr, exp;
    logic          cmd_wr[NREQ];
    logic [BW-1:0] cmd_addr[NREQ];
    logic [31:0]   cmd_wd[NREQ];
    xfer_t x;
    presetn   = 1'b0;
    use_fixed = 0;
    rand_mode = 1'b1;
    for (int k = 0; k < NREQ; k++) begin
      cmd_wr[k] = 1'($urandom_range(0, 1)); cmd_addr[k] = BW'($urandom); cmd_wd[k] = $urandom;
      set_cmd(k, cmd_wr[k], cmd_addr[k], cmd_wd[k]);
    end
    i_req = '1;
    repeat (2) @(posedge pclk);
    slv_log.delete();
    to_t0(t0);
    presetn = 1'b1;
    ptr     = NREQ - 1;
    prev_at = -1;
    for (int n = 0; n < 60; n++) begin
      wait_ack(20, idx, at);
      exp = (ptr + 1) % NREQ;
      ptr = exp;
      checks++; if (idx !== exp) begin failures++; $display("FAIL rnd_order n=%0d got=%0d exp=%0d", n, idx, exp); end
      if (idx < 0) break;
      if (slv_log.size() == 0) begin
        checks++; failures++; $display("FAIL rnd_log n=%0d got empty exp one transfer", n); break;
      end
      x = slv_log.pop_front();
      checks++; if ({x.addr, x.wr} !== {cmd_addr[exp], cmd_wr[exp]} || (cmd_wr[exp] && x.wdata !== cmd_wd[exp])) begin failures++;
        $display("FAIL rnd_cmd n=%0d got=%h/%b/%h exp=%h/%b/%h", n, x.addr, x.wr, x.wdata, cmd_addr[exp], cmd_wr[exp], cmd_wd[exp]); end
      checks++; if (o_err !== x.err || o_rdata !== (cmd_wr[exp] ? 32'h0 : rd_fn(cmd_addr[exp]))) begin failures++;
        $display("FAIL rnd_resp n=%0d got=%b/%h exp err=%b", n, o_err, o_rdata, x.err); end
      checks++; if (at !== x.at + 1 || (prev_at >= 0 && at - prev_at !== 3 + x.waits)) begin failures++;
        $display("FAIL rnd_timing n=%0d got at=%0d prev=%0d done=%0d waits=%0d", n, at, prev_at, x.at, x.waits); end
      prev_at = at;
      cmd_wr[exp] = 1'($urandom_range(0, 1)); cmd_addr[exp] = BW'($urandom); cmd_wd[exp] = $urandom;
      set_cmd(exp, cmd_wr[exp], cmd_addr[exp], cmd_wd[exp]);
    end
    i_req     = '0;
    rand_mode = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_wait();
    test_slverr();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_random();
    repeat (3) @(posedge pclk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no completion exp finish before 500000");
    $fatal(1, "watchdog");
  end

endmodule : tb_hgw_apb_mst_arb
